// File: rtl/game_pkg.sv
// Shared definitions for the fighting-game datapath: player state codes,
// hit flag codes, game-state constants, winner codes and box helpers.
package game_pkg;

    typedef enum logic [3:0] {
        S_IDLE           = 4'd0,
        S_MOVE_FWD       = 4'd1,
        S_MOVE_BWD       = 4'd2,
        S_B_ATTACK_START = 4'd3,
        S_B_ATTACK_END   = 4'd4,
        S_B_ATTACK_PULL  = 4'd5,
        S_D_ATTACK_START = 4'd6,
        S_D_ATTACK_END   = 4'd7,
        S_D_ATTACK_PULL  = 4'd8,
        S_HITSTUN        = 4'd9,
        S_BLOCKSTUN      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        notHit           = 2'b00,
        hitByBasic       = 2'b01,
        hitByDirectional = 2'b10
    } hit_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam logic [2:0] GS_FIGHT = 3'd2;

    typedef struct packed {
        logic [9:0] x1;
        logic [9:0] x2;
        logic [9:0] y1;
        logic [9:0] y2;
    } box_t;

    // Inclusive rectangle overlap; touching edges count as contact.
    function automatic logic boxes_overlap(input box_t a, input box_t b);
        return (a.x1 <= b.x2) && (b.x1 <= a.x2) &&
               (a.y1 <= b.y2) && (b.y1 <= a.y2);
    endfunction

    // Subtraction that floors at zero instead of wrapping.
    function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : 3'd0;
    endfunction

endpackage

// File: rtl/hit_channel.sv
// One attack direction: attacker hitboxes vs. defender hurtbox.
// Owns the landed latch, the DETECT/FLAG/APPLY pipeline and the
// defender's health, block meter and block-regen counter.
module hit_channel
    import game_pkg::*;
#(
    parameter int HEALTH_MAX  = 5,
    parameter int BLOCK_MAX   = 3,
    parameter int DMG_BASIC   = 1,
    parameter int DMG_DIR     = 2,
    parameter int BLOCK_REGEN = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_fight,
    input  logic       i_round_over,
    input  logic [3:0] i_atk_state,
    input  logic [3:0] i_def_state,
    input  logic [9:0] i_basic_x1,
    input  logic [9:0] i_basic_x2,
    input  logic [9:0] i_basic_y1,
    input  logic [9:0] i_basic_y2,
    input  logic [9:0] i_dir_x1,
    input  logic [9:0] i_dir_x2,
    input  logic [9:0] i_dir_y1,
    input  logic [9:0] i_dir_y2,
    input  logic [9:0] i_hurt_x1,
    input  logic [9:0] i_hurt_x2,
    input  logic [9:0] i_hurt_y1,
    input  logic [9:0] i_hurt_y2,
    output logic [1:0] o_hit_flag,
    output logic [2:0] o_health,
    output logic [2:0] o_block
);

    localparam logic [2:0] L_HEALTH_MAX = 3'(HEALTH_MAX);
    localparam logic [2:0] L_BLOCK_MAX  = 3'(BLOCK_MAX);
    localparam logic [2:0] L_DMG_BASIC  = 3'(DMG_BASIC);
    localparam logic [2:0] L_DMG_DIR    = 3'(DMG_DIR);
    localparam int         REGEN_W      = (BLOCK_REGEN > 2) ? $clog2(BLOCK_REGEN) : 1;
    localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(BLOCK_REGEN - 1);

    box_t w_basic;
    box_t w_dir;
    box_t w_hurt;
    logic w_atk_basic;
    logic w_atk_dir;
    logic w_def_hittable;
    hit_t w_detect;
    logic [2:0] w_dmg;

    logic               r_landed;
    hit_t               r_flag;
    hit_t               r_apply;
    logic [2:0]         r_health;
    logic [2:0]         r_block;
    logic [REGEN_W-1:0] r_regen_cnt;

    assign w_basic = {i_basic_x1, i_basic_x2, i_basic_y1, i_basic_y2};
    assign w_dir   = {i_dir_x1, i_dir_x2, i_dir_y1, i_dir_y2};
    assign w_hurt  = {i_hurt_x1, i_hurt_x2, i_hurt_y1, i_hurt_y2};

    assign w_atk_basic    = (i_atk_state == S_B_ATTACK_END);
    assign w_atk_dir      = (i_atk_state == S_D_ATTACK_END);
    assign w_def_hittable = (i_def_state != S_HITSTUN) && (i_def_state != S_BLOCKSTUN);

    // DETECT stage: only the hitbox matching the attack phase is tested.
    always_comb begin
        // NOTE: default first so every path assigns w_detect and no latch is inferred.
        w_detect = notHit;
        if (i_fight && !i_round_over && !r_landed && w_def_hittable) begin
            if (w_atk_basic && boxes_overlap(w_basic, w_hurt)) begin
                w_detect = hitByBasic;
            end else if (w_atk_dir && boxes_overlap(w_dir, w_hurt)) begin
                w_detect = hitByDirectional;
            end
        end
    end

    assign w_dmg = (r_apply == hitByBasic) ? L_DMG_BASIC : L_DMG_DIR;

    // FLAG/APPLY pipeline and the one-hit-per-attack latch.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
        if (rst || !i_fight) begin
            r_landed <= 1'b0;
            r_flag   <= notHit;
            r_apply  <= notHit;
        end else begin
            r_flag  <= w_detect;
            r_apply <= r_flag;
            if (w_detect != notHit) begin
                r_landed <= 1'b1;
            end else if (!w_atk_basic && !w_atk_dir) begin
                r_landed <= 1'b0;
            end
        end
    end

    // Defender health/block: damage commits only once the defender is stunned; block regenerates when idle.
    always_ff @(posedge clk) begin
        if (rst || !i_fight) begin
            r_health    <= L_HEALTH_MAX;
            r_block     <= L_BLOCK_MAX;
            r_regen_cnt <= '0;
        end else begin
            if (r_apply != notHit && i_def_state == S_HITSTUN) begin
                r_health <= sat_sub(r_health, w_dmg);
            end
            if (r_apply != notHit && i_def_state == S_BLOCKSTUN) begin
                r_block     <= sat_sub(r_block, 3'd1);
                r_regen_cnt <= '0;
            end else if (r_block >= L_BLOCK_MAX) begin
                r_regen_cnt <= '0;
            end else if (r_regen_cnt == REGEN_LAST) begin
                r_regen_cnt <= '0;
                r_block     <= r_block + 3'd1;
            end else begin
                r_regen_cnt <= r_regen_cnt + 1'b1;
            end
        end
    end

    assign o_hit_flag = r_flag;
    assign o_health   = r_health;
    assign o_block    = r_block;

endmodule

// File: rtl/hit_arbiter.sv
// Combat referee: one hit_channel per attack direction, plus KO detection
// and round result reporting to the game-state controller.
module hit_arbiter
    import game_pkg::*;
#(
    parameter int HEALTH_MAX  = 5,
    parameter int BLOCK_MAX   = 3,
    parameter int DMG_BASIC   = 1,
    parameter int DMG_DIR     = 2,
    parameter int BLOCK_REGEN = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] gamestate,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_basic_x1,
    input  logic [9:0] p1_basic_x2,
    input  logic [9:0] p1_basic_y1,
    input  logic [9:0] p1_basic_y2,
    input  logic [9:0] p1_dir_x1,
    input  logic [9:0] p1_dir_x2,
    input  logic [9:0] p1_dir_y1,
    input  logic [9:0] p1_dir_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_basic_x1,
    input  logic [9:0] p2_basic_x2,
    input  logic [9:0] p2_basic_y1,
    input  logic [9:0] p2_basic_y2,
    input  logic [9:0] p2_dir_x1,
    input  logic [9:0] p2_dir_x2,
    input  logic [9:0] p2_dir_y1,
    input  logic [9:0] p2_dir_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic [1:0] p1_hitFlag,
    output logic [1:0] p2_hitFlag,
    output logic [2:0] p1_health,
    output logic [2:0] p2_health,
    output logic [2:0] p1_block,
    output logic [2:0] p2_block,
    output logic       round_over,
    output logic [1:0] winner
);

    logic    w_fight;
    winner_t w_ko_winner;
    logic    r_round_over;
    winner_t r_winner;

    assign w_fight = (gamestate == GS_FIGHT);

    hit_channel #(
        .HEALTH_MAX(HEALTH_MAX), .BLOCK_MAX(BLOCK_MAX), .DMG_BASIC(DMG_BASIC),
        .DMG_DIR(DMG_DIR), .BLOCK_REGEN(BLOCK_REGEN)
    ) u_p1_on_p2 (
        .clk(clk), .rst(rst), .i_fight(w_fight), .i_round_over(r_round_over),
        .i_atk_state(p1_state), .i_def_state(p2_state),
        .i_basic_x1(p1_basic_x1), .i_basic_x2(p1_basic_x2),
        .i_basic_y1(p1_basic_y1), .i_basic_y2(p1_basic_y2),
        .i_dir_x1(p1_dir_x1), .i_dir_x2(p1_dir_x2),
        .i_dir_y1(p1_dir_y1), .i_dir_y2(p1_dir_y2),
        .i_hurt_x1(p2_hurt_x1), .i_hurt_x2(p2_hurt_x2),
        .i_hurt_y1(p2_hurt_y1), .i_hurt_y2(p2_hurt_y2),
        .o_hit_flag(p2_hitFlag), .o_health(p2_health), .o_block(p2_block)
    );

    hit_channel #(
        .HEALTH_MAX(HEALTH_MAX), .BLOCK_MAX(BLOCK_MAX), .DMG_BASIC(DMG_BASIC),
        .DMG_DIR(DMG_DIR), .BLOCK_REGEN(BLOCK_REGEN)
    ) u_p2_on_p1 (
        .clk(clk), .rst(rst), .i_fight(w_fight), .i_round_over(r_round_over),
        .i_atk_state(p2_state), .i_def_state(p1_state),
        .i_basic_x1(p2_basic_x1), .i_basic_x2(p2_basic_x2),
        .i_basic_y1(p2_basic_y1), .i_basic_y2(p2_basic_y2),
        .i_dir_x1(p2_dir_x1), .i_dir_x2(p2_dir_x2),
        .i_dir_y1(p2_dir_y1), .i_dir_y2(p2_dir_y2),
        .i_hurt_x1(p1_hurt_x1), .i_hurt_x2(p1_hurt_x2),
        .i_hurt_y1(p1_hurt_y1), .i_hurt_y2(p1_hurt_y2),
        .o_hit_flag(p1_hitFlag), .o_health(p1_health), .o_block(p1_block)
    );

    // Decide who survived; a double KO in the same cycle is a draw.
    always_comb begin
        w_ko_winner = WIN_NONE;
        if (p1_health == 3'd0 && p2_health == 3'd0) begin
            w_ko_winner = WIN_DRAW;
        end else if (p2_health == 3'd0) begin
            w_ko_winner = WIN_P1;
        end else if (p1_health == 3'd0) begin
            w_ko_winner = WIN_P2;
        end
    end

    // Latch the round result on the first KO and hold it until the fight ends.
    always_ff @(posedge clk) begin
        if (rst || !w_fight) begin
            r_round_over <= 1'b0;
            r_winner     <= WIN_NONE;
        end else if (!r_round_over && w_ko_winner != WIN_NONE) begin
            r_round_over <= 1'b1;
            r_winner     <= w_ko_winner;
        end
    end

    assign round_over = r_round_over;
    assign winner     = r_winner;

endmodule
